waveform_to_pipe: RTL and testbench
===================================

WAVEFORM_TO_PIPE -- requirements
Module: waveform_to_pipe

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 1024, number of 32-bit samples per capture (power of two).
REQ-002 The block SHALL provide parameter AW, default 10, address width, equal to log2(DEPTH).
REQ-003 The block SHALL provide port ti_clk  input  1  the single clock for all logic.
REQ-004 The block SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL provide port arm  input  1  one-cycle pulse that starts a new capture.
REQ-006 The block SHALL provide port sample_valid  input  1  qualifies sample_data on this cycle.
REQ-007 The block SHALL provide port sample_data  input  32  waveform sample to store.
REQ-008 The block SHALL provide port trigger  input  1  capture start event (used only with the configuration macro).
REQ-009 The block SHALL provide port pipe_read  input  1  host pipe-out read strobe, one 16-bit word per cycle.
REQ-010 The block SHALL provide port pipe_data  output  16  current pipe-out word.
REQ-011 The block SHALL provide port done_capture  output  1  buffer full, ready for readout.
REQ-012 The block SHALL provide port underrun  output  1  sticky flag: pipe_read was asserted while no data was available.

Function
REQ-013 The block SHALL implement states IDLE, CAPTURE, FULL and READOUT.
REQ-014 IDLE -> CAPTURE on arm; CAPTURE -> FULL after the DEPTH-th accepted sample; FULL -> READOUT on the first pipe_read; READOUT -> IDLE after the 2*DEPTH-th pipe_read.
REQ-015 In CAPTURE, each cycle with sample_valid=1 SHALL write sample_data to mem[wr_index] and increment wr_index; sample_valid in any other state SHALL be ignored.
REQ-016 A sample accepted on the same cycle as arm SHALL NOT be stored; the first stored sample SHALL be the first valid sample after the arm cycle.
REQ-017 done_capture SHALL be registered, rise on the cycle after the DEPTH-th write, and fall on the cycle after the final pipe_read or an arm.
REQ-018 Readout order SHALL be mem[0] low half, mem[0] high half, mem[1] low half, and so on, through mem[DEPTH-1] high half.
REQ-019 pipe_data SHALL be first-word-fall-through: in FULL and READOUT it SHALL present the next unread word combinationally, and each ti_clk edge with pipe_read=1 SHALL advance to the following word.
REQ-020 pipe_data SHALL be 16'h0000 in IDLE and CAPTURE.
REQ-021 pipe_read in IDLE or CAPTURE SHALL be ignored, SHALL leave state unchanged, and SHALL set underrun.
REQ-022 The read index SHALL NOT wrap; after the last word the block SHALL return to IDLE and clear the read index and half-select.
REQ-023 arm in any state SHALL abort the operation in progress, clear wr_index, the read index and the half-select, and enter CAPTURE (or ARMED, see REQ-029); arm SHALL take priority over sample_valid and pipe_read on the same cycle.
REQ-024 underrun SHALL be cleared only by arm or by reset.

Reset
REQ-025 reset SHALL asynchronously force state=IDLE, wr_index=0, read index=0, half-select=low, done_capture=0 and underrun=0.
REQ-026 pipe_data SHALL read 16'h0000 while reset is asserted and after it is released.
REQ-027 Memory contents SHALL NOT be cleared by reset and SHALL NOT be observable before the next complete capture.
REQ-028 A reset asserted mid-capture or mid-readout SHALL discard the partial operation; no further writes or word advances SHALL occur until a new arm.

Configuration
REQ-029 With macro WAVEFORM_TO_PIPE_TRIGGER_EN defined, the block SHALL add state ARMED: arm enters ARMED, a registered rising edge of trigger enters CAPTURE, and samples in ARMED SHALL be ignored.
REQ-030 Without WAVEFORM_TO_PIPE_TRIGGER_EN, arm SHALL enter CAPTURE directly, the trigger input SHALL be ignored, and no ARMED state SHALL exist.

Verification
REQ-031 Bench SHALL cover: arm, then 1024 valid samples with sample_data=i*65537 -> done_capture=1 one cycle after the last write; 2048 reads yield 0x0000,0x0000,0x0001,0x0001,...,0x03FF,0x03FF; state returns to IDLE.
REQ-032 Bench SHALL cover: sample_valid toggling 1/0 during capture -> exactly 1024 stored samples, and done_capture is delayed accordingly.
REQ-033 Bench SHALL cover: pipe_read pulsed in IDLE -> pipe_data=0x0000, underrun=1, no state change; a following arm -> underrun=0.
REQ-034 Bench SHALL cover: arm asserted after 500 samples -> wr_index=0, and the next 1024 samples form the new buffer with no old data present.
REQ-035 Bench SHALL cover: reset pulsed after 300 of 2048 reads -> done_capture=0, pipe_data=0x0000, state=IDLE.
REQ-036 With WAVEFORM_TO_PIPE_TRIGGER_EN defined, bench SHALL cover: arm, 10 samples, trigger rise, then samples 100.. -> mem[0]=100.

Source files
------------

// File: rtl/waveform_to_pipe.sv
// waveform_to_pipe: captures DEPTH 32-bit waveform samples into an on-chip
// buffer. The host then drains the buffer as a pipe-out stream of 16-bit
// words, sending the low half of each sample before its high half.
//
// Optional feature: define WAVEFORM_TO_PIPE_TRIGGER_EN to add an ARMED state.
// In that build, arm waits for a registered rising edge of trigger before
// capturing. In the default build, trigger is ignored and arm starts capture
// immediately.
module waveform_to_pipe #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        ti_clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        sample_valid,
    input  logic [31:0] sample_data,
    input  logic        trigger,
    input  logic        pipe_read,
    output logic [15:0] pipe_data,
    output logic        done_capture,
    output logic        underrun
);

`ifdef WAVEFORM_TO_PIPE_TRIGGER_EN
    typedef enum logic [2:0] {IDLE, CAPTURE, FULL, READOUT, ARMED} state_t;
`else
    typedef enum logic [1:0] {IDLE, CAPTURE, FULL, READOUT} state_t;
`endif

    localparam logic [AW-1:0] LAST_INDEX = AW'(DEPTH - 1);

    state_t        state_q;
    logic [AW-1:0] wr_index_q;
    logic [AW-1:0] rd_index_q;
    logic          half_q;       // 0: low half of mem[rd_index_q], 1: high half
    logic          done_q;
    logic          underrun_q;
    logic [31:0]   mem [DEPTH];

    logic          has_data;     // buffer holds unread words
    logic          wr_en;
    logic          trig_rise;

    assign has_data = (state_q == FULL) || (state_q == READOUT);
    assign wr_en    = (state_q == CAPTURE) && sample_valid && !arm;

`ifdef WAVEFORM_TO_PIPE_TRIGGER_EN
    logic trig_d1_q;
    logic trig_d2_q;

    // Register trigger twice so capture starts on a clean, registered rising edge.
    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            trig_d1_q <= 1'b0;
            trig_d2_q <= 1'b0;
        end else begin
            trig_d1_q <= trigger;
            trig_d2_q <= trig_d1_q;
        end
    end

    assign trig_rise = trig_d1_q && !trig_d2_q;
`else
    logic unused_trigger;
    assign unused_trigger = trigger;
    assign trig_rise      = 1'b0;
`endif

    // Control FSM: capture and readout indices, half-select, and the sticky flags.
    // NOTE: every clocked block uses non-blocking (<=) assignments so that all
    // registers update together from the values they held before the edge.
    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_index_q <= '0;
            rd_index_q <= '0;
            half_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else if (arm) begin
`ifdef WAVEFORM_TO_PIPE_TRIGGER_EN
            state_q    <= ARMED;
`else
            state_q    <= CAPTURE;
`endif
            wr_index_q <= '0;
            rd_index_q <= '0;
            half_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (pipe_read && !has_data) begin
                underrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
`ifdef WAVEFORM_TO_PIPE_TRIGGER_EN
                ARMED: begin
                    if (trig_rise) begin
                        state_q <= CAPTURE;
                    end
                end
`endif
                CAPTURE: begin
                    if (sample_valid) begin
                        wr_index_q <= wr_index_q + 1'b1;
                        if (wr_index_q == LAST_INDEX) begin
                            state_q <= FULL;
                            done_q  <= 1'b1;
                        end
                    end
                end
                FULL, READOUT: begin
                    if (pipe_read) begin
                        state_q <= READOUT;
                        half_q  <= ~half_q;
                        if (half_q) begin
                            if (rd_index_q == LAST_INDEX) begin
                                state_q    <= IDLE;
                                rd_index_q <= '0;
                                done_q     <= 1'b0;
                            end else begin
                                rd_index_q <= rd_index_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Sample buffer write port.
    // NOTE: the buffer is intentionally not reset; the FSM makes sure stale
    // contents are never presented before a fresh capture has completed.
    always_ff @(posedge ti_clk) begin
        if (wr_en) begin
            mem[wr_index_q] <= sample_data;
        end
    end

    // First-word-fall-through output: show the next unread half-word, or zero when no data is held.
    // NOTE: pipe_data gets a default first so that no path through the block infers a latch.
    always_comb begin
        pipe_data = 16'h0000;
        if (has_data) begin
            pipe_data = half_q ? mem[rd_index_q][31:16] : mem[rd_index_q][15:0];
        end
    end

    assign done_capture = done_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_waveform_to_pipe.sv
// Self-checking bench for waveform_to_pipe.
//
// The reference model describes the block at the level of a sample list and a
// queue of words still to be read. Every negative clock edge it is compared
// with pipe_data, done_capture and underrun. Directed scenarios add a few
// literal expectations that pin down the model itself.
module tb_waveform_to_pipe;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic        ti_clk = 1'b0;
    logic        reset  = 1'b0;
    logic        arm;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic        trigger;
    logic        pipe_read;
    logic [15:0] pipe_data;
    logic        done_capture;
    logic        underrun;

    int total = 0;
    int bad   = 0;

    always #5 ti_clk = ~ti_clk;

    waveform_to_pipe #(.DEPTH(DEPTH), .AW(AW)) dut (
        .ti_clk       (ti_clk),
        .reset        (reset),
        .arm          (arm),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trigger      (trigger),
        .pipe_read    (pipe_read),
        .pipe_data    (pipe_data),
        .done_capture (done_capture),
        .underrun     (underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_capturing;          // collecting samples
    bit          m_waiting;            // armed, waiting for the trigger edge
    bit          m_underrun;
    logic [31:0] m_samples[$];         // samples captured so far
    logic [15:0] m_words[$];           // words the host has still to read
    bit          trig_prev1, trig_prev2;

    task automatic model_step();
        bit rise;
        if (reset) begin
            m_capturing = 0; m_waiting = 0; m_underrun = 0;
            m_samples.delete(); m_words.delete();
            trig_prev1 = 0; trig_prev2 = 0;
            return;
        end
        rise = trig_prev1 && !trig_prev2;
        if (arm) begin
            m_samples.delete(); m_words.delete();
            m_underrun = 0;
`ifdef WAVEFORM_TO_PIPE_TRIGGER_EN
            m_waiting = 1; m_capturing = 0;
`else
            m_waiting = 0; m_capturing = 1;
`endif
        end else begin
            if (pipe_read && m_words.size() == 0) m_underrun = 1;
            if (m_waiting) begin
                if (rise) begin
                    m_waiting = 0;
                    m_capturing = 1;
                end
            end else if (m_capturing) begin
                if (sample_valid) begin
                    m_samples.push_back(sample_data);
                    if (m_samples.size() == DEPTH) begin
                        foreach (m_samples[i]) begin
                            m_words.push_back(m_samples[i][15:0]);
                            m_words.push_back(m_samples[i][31:16]);
                        end
                        m_samples.delete();
                        m_capturing = 0;
                    end
                end
            end else if (m_words.size() != 0 && pipe_read) begin
                void'(m_words.pop_front());
            end
        end
        trig_prev2 = trig_prev1;
        trig_prev1 = trigger;
    endtask

    initial forever begin
        @(posedge ti_clk or posedge reset);
        model_step();
    end

    // Continuous compare against the model.
    initial forever begin
        @(negedge ti_clk);
        if (!reset) begin
            check("cmp_pipe_data", pipe_data, (m_words.size() != 0) ? m_words[0] : 16'h0000);
            check("cmp_done", done_capture, (m_words.size() != 0) ? 1 : 0);
            check("cmp_underrun", underrun, m_underrun);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge ti_clk);
    endtask

    task automatic idle_inputs();
        arm = 0; sample_valid = 0; sample_data = '0; trigger = 0; pipe_read = 0;
    endtask

    // Arm while a valid sample is present; that sample must not be stored.
    task automatic do_arm();
        arm = 1; sample_valid = 1; sample_data = 32'hDEAD_BEEF;
        cyc();
        arm = 0; sample_valid = 0;
    endtask

    initial begin
        logic [31:0] first_new;
        int n;
        idle_inputs();
        #1 reset = 1'b1;
        cyc();
        check("rst_pipe_data", pipe_data, 16'h0000);
        check("rst_done", done_capture, 0);
        check("rst_underrun", underrun, 0);
        cyc();
        reset = 1'b0;
        cyc();
        check("post_rst_pipe_data", pipe_data, 16'h0000);

        // Full capture with data i*65537, then full readout.
        do_arm();
        for (int i = 0; i < DEPTH; i++) begin
            sample_valid = 1; sample_data = i * 65537;
            if (i == DEPTH - 1) check("t1_done_before_last", done_capture, 0);
            cyc();
        end
        sample_valid = 0;
        check("t1_done_after_last", done_capture, 1);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (i == 0)    check("t1_word0", pipe_data, 16'h0000);
            if (i == 3)    check("t1_word3", pipe_data, 16'h0001);
            if (i == 2047) check("t1_word2047", pipe_data, 16'h03FF);
            pipe_read = 1;
            cyc();
        end
        pipe_read = 0;
        check("t1_done_cleared", done_capture, 0);
        check("t1_pipe_idle", pipe_data, 16'h0000);

        // pipe_read in IDLE: underrun, no state change; arm clears it.
        pipe_read = 1; cyc(); pipe_read = 0;
        check("t3_pipe_idle", pipe_data, 16'h0000);
        check("t3_underrun_set", underrun, 1);
        check("t3_still_idle", done_capture, 0);
        do_arm();
        check("t3_underrun_cleared", underrun, 0);

        // Alternating sample_valid: 1024 stores span 2047 cycles.
        for (int i = 0; i < 2 * DEPTH; i++) begin
            sample_valid = (i % 2 == 0); sample_data = $urandom;
            if (i == 2 * DEPTH - 2) check("t2_done_before_last", done_capture, 0);
            cyc();
            if (i == 2 * DEPTH - 2) check("t2_done_after_last", done_capture, 1);
        end
        sample_valid = 0;

        // Abort after 500 samples; the new buffer must hold only new data.
        do_arm();
        for (int i = 0; i < 500; i++) begin
            sample_valid = 1; sample_data = 32'hAAAA_0000 | i; cyc();
        end
        sample_valid = 0;
        do_arm();
        first_new = 32'h1234_5678;
        for (int i = 0; i < DEPTH; i++) begin
            sample_valid = 1; sample_data = (i == 0) ? first_new : $urandom; cyc();
        end
        sample_valid = 0;
        check("t4_done", done_capture, 1);
        check("t4_first_word", pipe_data, 16'h5678);

        // Reset after 300 reads.
        for (int i = 0; i < 300; i++) begin
            pipe_read = 1; cyc();
        end
        pipe_read = 0;
        reset = 1'b1;
        cyc();
        check("t5_rst_done", done_capture, 0);
        check("t5_rst_pipe", pipe_data, 16'h0000);
        reset = 1'b0;
        pipe_read = 1; cyc(); pipe_read = 0;
        check("t5_idle_pipe", pipe_data, 16'h0000);
        check("t5_idle_underrun", underrun, 1);
        check("t5_idle_done", done_capture, 0);

        // Randomized capture and readout with stray reads and trigger activity.
        do_arm();
        n = 0;
        while (!done_capture && n < 8000) begin
            sample_valid = $urandom_range(0, 1);
            sample_data  = $urandom;
            pipe_read    = ($urandom_range(0, 7) == 0);
`ifndef WAVEFORM_TO_PIPE_TRIGGER_EN
            trigger      = $urandom_range(0, 1);
`endif
            cyc();
            n++;
        end
        idle_inputs();
        check("rand_fill_done", done_capture, 1);
        n = 0;
        while (done_capture && n < 12000) begin
            pipe_read   = $urandom_range(0, 1);
            sample_valid = $urandom_range(0, 1);
            sample_data = $urandom;
            cyc();
            n++;
        end
        idle_inputs();
        check("rand_drain_done", done_capture, 0);

`ifdef WAVEFORM_TO_PIPE_TRIGGER_EN
        // Trigger mode: samples before the trigger edge are discarded.
        do_arm();
        for (int i = 1; i <= 10; i++) begin
            sample_valid = 1; sample_data = i; cyc();
        end
        sample_valid = 0;
        trigger = 1;
        cyc(); cyc(); cyc();
        for (int i = 0; i < DEPTH; i++) begin
            sample_valid = 1; sample_data = 100 + i; cyc();
        end
        sample_valid = 0;
        check("trig_done", done_capture, 1);
        check("trig_mem0", pipe_data, 16'd100);
        trigger = 0;
`endif

        cyc(); cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
